// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fb_writer
//  Purpose  : Queues shaded pixels and writes them one at a time into a
//             double-buffered SDRAM frame buffer, swapping on the frame's last pixel.
//  Revision : 1.0  initial release
// ============================================================================
module fb_writer #(
    parameter int          WIDTH     = 800,
    parameter int          HEIGHT    = 600,
    parameter int          DEPTH     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid_i,
    output logic                     pix_ready_o,
    input  logic [9:0]               pix_x_i,
    input  logic [9:0]               pix_y_i,
    input  logic [15:0]              pix_rgb_i,
    input  logic                     pix_last_i,
    output logic [23:0]              wr_addr_o,
    output logic [15:0]              wr_data_o,
    output logic                     wr_enable_o,
    input  logic                     busy_i,
    output logic                     front_sel_o,
    output logic                     frame_done_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [15:0]              drop_count_o
);
    localparam int          AW          = $clog2(DEPTH);
    localparam int          LW          = AW + 1;
    localparam int          EW          = 36;
    localparam logic [23:0] FRAME_WORDS = 24'(WIDTH * HEIGHT);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [23:0]   wr_addr_q;
    logic [15:0]   wr_data_q;
    logic          front_sel_q;
    logic [15:0]   drop_q;

    logic [18:0]   w_offset;
    logic          w_in_range, w_accept, w_push, w_drop, w_pop, w_load;
    logic [EW-1:0] w_head;

    // Default geometry uses a shift-add for y*800; other widths fall back to a constant multiply.
    generate
        if (WIDTH == 800) begin : g_offset_shift
            assign w_offset = ({9'd0, pix_y_i} << 9) + ({9'd0, pix_y_i} << 8)
                            + ({9'd0, pix_y_i} << 5) + {9'd0, pix_x_i};
        end else begin : g_offset_mul
            assign w_offset = 19'(32'(pix_y_i) * WIDTH + 32'(pix_x_i));
        end
    endgenerate

    assign w_in_range  = (32'(pix_x_i) < WIDTH) && (32'(pix_y_i) < HEIGHT);
    assign pix_ready_o = (level_q != FULL_LEVEL);
    assign w_accept    = pix_valid_i && pix_ready_o;
    assign w_push      = w_accept && w_in_range;
    assign w_drop      = w_accept && !w_in_range;
    assign w_head      = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (level_q != '0 && !busy_i) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (busy_i) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!busy_i) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_enable_o  = (state_q == S_ISSUE);
        w_pop        = (state_q == S_WAIT_DONE) && !busy_i;
        frame_done_o = w_pop && w_head[0];
        w_load       = (state_q == S_IDLE) && (state_d == S_ISSUE);
    end

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) fifo_q[wr_ptr_q] <= {w_offset, pix_rgb_i, pix_last_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            front_sel_q <= 1'b1;
            drop_q      <= '0;
        end else begin
            level_q <= level_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            // Buffer select is sampled as the write launches, so pixels queued behind a swap land in the new back buffer.
            if (w_load) begin
                wr_addr_q <= BASE_ADDR + (front_sel_q ? 24'd0 : FRAME_WORDS) + {5'd0, w_head[35:17]};
                wr_data_q <= w_head[16:1];
            end
            if (frame_done_o) front_sel_q <= !front_sel_q;
            if (w_drop && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign front_sel_o  = front_sel_q;
    assign fifo_level_o = level_q;
    assign drop_count_o = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_writer
//  Purpose  : Directed self-checking bench for fb_writer with a simple
//             SDRAM controller busy model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [15:0] pix_rgb = '0;
    logic        pix_last = 1'b0;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic        busy;
    logic        front_sel;
    logic        frame_done;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    logic        force_busy = 1'b0;
    int          bcnt = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    int          viol = 0;
    logic [23:0] wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    fb_writer dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .pix_x_i      (pix_x),
        .pix_y_i      (pix_y),
        .pix_rgb_i    (pix_rgb),
        .pix_last_i   (pix_last),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_enable_o  (wr_enable),
        .busy_i       (busy),
        .front_sel_o  (front_sel),
        .frame_done_o (frame_done),
        .fifo_level_o (fifo_level),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after a write request and holds for 4 cycles.
    assign busy = force_busy | (bcnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) bcnt <= 0;
        else if (wr_enable) bcnt <= 4;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (!rst) begin
            if (pix_valid && pix_ready) begin
                acc_cyc <= cyc;
                acc_cnt <= acc_cnt + 1;
            end
            if (wr_enable) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                wc_q.push_back(cyc);
                if (busy) viol <= viol + 1;
            end
            if (frame_done) fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [15:0] rgb, input logic last);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_rgb   = rgb;
        pix_last  = last;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int k;
        k = 0;
        while (!(fifo_level == 0 && !busy && !wr_enable) && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {31'd0, (fifo_level == 0 && !busy && !wr_enable)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int a0;
        int fd0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_ready",    32'(pix_ready),  32'd1);
        check("rst_wren",     32'(wr_enable),  32'd0);
        check("rst_addr",     32'(wr_addr),    32'd0);
        check("rst_data",     32'(wr_data),    32'd0);
        check("rst_front",    32'(front_sel),  32'd1);
        check("rst_fdone",    32'(frame_done), 32'd0);
        check("rst_drop",     32'(drop_count), 32'd0);

        // Single pixel, latency and address
        base = wa_q.size();
        push(10'd3, 10'd2, 16'hF800, 1'b0);
        wait_idle(40);
        repeat (5) @(negedge clk);
        check("t1_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() > base) begin
            check("t1_addr", 32'(wa_q[base]), 32'h000643);
            check("t1_data", 32'(wd_q[base]), 32'h0000F800);
            check("t1_lat",  32'(wc_q[base] - acc_cyc), 32'd2);
        end
        check("t1_level", 32'(fifo_level), 32'd0);

        // Fill while busy, then drain in order
        @(negedge clk);
        force_busy = 1'b1;
        base = wa_q.size();
        a0   = acc_cnt;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_x     = 10'(i);
            pix_y     = 10'd0;
            pix_rgb   = 16'h1000 + 16'(i);
            pix_last  = 1'b0;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        check("t2_accepted", 32'(acc_cnt - a0), 32'd16);
        check("t2_ready",    32'(pix_ready),    32'd0);
        check("t2_level",    32'(fifo_level),   32'd16);
        check("t2_nwr_busy", 32'(wa_q.size() - base), 32'd0);
        force_busy = 1'b0;
        wait_idle(300);
        check("t2_nwr", 32'(wa_q.size() - base), 32'd16);
        if (wa_q.size() >= base + 16) begin
            for (int j = 0; j < 16; j++) begin
                check($sformatf("t2_addr%0d", j), 32'(wa_q[base + j]), 32'(j));
                check($sformatf("t2_data%0d", j), 32'(wd_q[base + j]), 32'h1000 + 32'(j));
            end
        end
        check("t2_viol", 32'(viol), 32'd0);

        // Frame swap on the last pixel
        base = wa_q.size();
        fd0  = fd_cnt;
        push(10'd799, 10'd599, 16'h07E0, 1'b1);
        push(10'd0,   10'd0,   16'h001F, 1'b0);
        wait_idle(60);
        check("t3_nwr", 32'(wa_q.size() - base), 32'd2);
        if (wa_q.size() >= base + 2) begin
            check("t3_addr0", 32'(wa_q[base]),     32'h0752FF);
            check("t3_addr1", 32'(wa_q[base + 1]), 32'h075300);
        end
        check("t3_fdone", 32'(fd_cnt - fd0), 32'd1);
        check("t3_front", 32'(front_sel),    32'd0);

        // Out-of-range pixels are dropped, including their last flag
        base = wa_q.size();
        fd0  = fd_cnt;
        push(10'd800, 10'd0,   16'h1234, 1'b0);
        push(10'd0,   10'd600, 16'h5678, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_nwr",   32'(wa_q.size() - base), 32'd0);
        check("t4_drop",  32'(drop_count), 32'd2);
        check("t4_front", 32'(front_sel),  32'd0);
        check("t4_ready", 32'(pix_ready),  32'd1);
        check("t4_fdone", 32'(fd_cnt - fd0), 32'd0);

        // Reset during WAIT_DONE with 5 entries queued
        base = wa_q.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_x     = 10'd10 + 10'(i);
            pix_y     = 10'd0;
            pix_rgb   = 16'h2000 + 16'(i);
            pix_last  = 1'b0;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        check("t5_level_pre", 32'(fifo_level), 32'd5);
        check("t5_nwr_pre",   32'(wa_q.size() - base), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_level", 32'(fifo_level), 32'd0);
        check("t5_wren",  32'(wr_enable),  32'd0);
        check("t5_front", 32'(front_sel),  32'd1);
        check("t5_ready", 32'(pix_ready),  32'd1);
        check("t5_drop",  32'(drop_count), 32'd0);
        repeat (20) @(negedge clk);
        check("t5_nwr_post", 32'(wa_q.size() - base), 32'd1);

        // Push coinciding with the pop of the only entry
        base = wa_q.size();
        push(10'd20, 10'd0, 16'hAAAA, 1'b0);
        repeat (6) @(negedge clk);
        check("t6_level_pre", 32'(fifo_level), 32'd1);
        check("t6_busy_pre",  32'(busy),       32'd0);
        pix_valid = 1'b1;
        pix_x     = 10'd21;
        pix_y     = 10'd0;
        pix_rgb   = 16'h5555;
        pix_last  = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        check("t6_level", 32'(fifo_level), 32'd1);
        wait_idle(40);
        check("t6_nwr", 32'(wa_q.size() - base), 32'd2);
        if (wa_q.size() >= base + 2) begin
            check("t6_addr0", 32'(wa_q[base]),     32'd20);
            check("t6_addr1", 32'(wa_q[base + 1]), 32'd21);
            check("t6_data1", 32'(wd_q[base + 1]), 32'h5555);
        end
        check("t6_viol", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 800, giving the visible pixels per line.
REQ-002 The block SHALL have parameter HEIGHT, default 600, giving the visible lines per frame.
REQ-003 The block SHALL have parameter DEPTH, default 16 (power of 2), giving the pixel FIFO entries.
REQ-004 The block SHALL have parameter BASE_ADDR, default 24'h000000, giving the SDRAM word address of buffer 0.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock (100 MHz domain); rst  in  1  synchronous active-high reset.
REQ-006 The block SHALL have these pixel-side ports: pix_valid  in  1  shading-stage pixel valid; pix_ready  out  1  block can accept; pix_x  in  10  column; pix_y  in  10  row; pix_rgb  in  16  RGB565 colour; pix_last  in  1  final pixel of frame.
REQ-007 The block SHALL have these SDRAM-controller-side ports: wr_addr  out  24  word address; wr_data  out  16  write data; wr_enable  out  1  write request pulse; busy  in  1  controller busy.
REQ-008 The block SHALL have these status ports: front_sel  out  1  buffer the display reads; frame_done  out  1  one-cycle swap pulse; fifo_level  out  $clog2(DEPTH)+1  occupancy; drop_count  out  16  discarded pixels.

Function
REQ-009 pix_ready SHALL equal (fifo_level != DEPTH); a pixel is accepted in any cycle with pix_valid && pix_ready.
REQ-010 For each accepted pixel with x<WIDTH and y<HEIGHT, the block SHALL enqueue {offset = y*WIDTH + x (19 bits, no multiplier for default: (y<<9)+(y<<8)+(y<<5)+x), rgb, last}.
REQ-011 For each accepted pixel with x>=WIDTH or y>=HEIGHT, the block SHALL enqueue nothing, SHALL ignore its pix_last, and SHALL increment drop_count, saturating at 16'hFFFF.
REQ-012 A push and a pop in the same cycle SHALL leave fifo_level unchanged; the FIFO SHALL drain strictly in order.
REQ-013 The write FSM SHALL have states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-014 IDLE SHALL go to ISSUE when the FIFO is non-empty and busy==0.
REQ-015 ISSUE SHALL last exactly 1 cycle, with wr_enable=1 and wr_addr/wr_data driven from the FIFO head, and SHALL then go to WAIT_ACK.
REQ-016 WAIT_ACK SHALL go to WAIT_DONE when busy==1.
REQ-017 WAIT_DONE SHALL pop the head, and return to IDLE, in the first cycle in which busy==0.
REQ-018 wr_enable SHALL be 0 in every state except ISSUE; wr_addr/wr_data SHALL hold their last values outside ISSUE.
REQ-019 wr_addr SHALL be BASE_ADDR + (back_sel ? WIDTH*HEIGHT : 0) + offset, where back_sel = ~front_sel, evaluated at ISSUE time, not at enqueue time.
REQ-020 Latency: a pixel accepted in cycle N into an empty FIFO, with busy==0, SHALL see wr_enable=1 in cycle N+2.
REQ-021 When the entry with last=1 is popped in WAIT_DONE, front_sel SHALL toggle and frame_done SHALL pulse high for exactly that cycle.
REQ-022 Entries queued behind the last entry SHALL be addressed to the new back buffer.
REQ-023 busy already high in IDLE SHALL block issue; nothing in the block SHALL time out.

Reset
REQ-024 While rst=1 at a clk edge, the block SHALL clear all state: FSM=IDLE, FIFO empty (fifo_level=0, pix_ready=1), wr_enable=0, wr_addr=0, wr_data=0, front_sel=1 (back buffer 0), frame_done=0, drop_count=0.
REQ-025 A reset mid-write SHALL abandon the in-flight write and discard all queued pixels, with no extra wr_enable pulse afterwards.

Verification
REQ-026 Reset; push (3,2,16'hF800,last=0) with the controller model (busy rises 1 cycle after wr_enable, holds 4 cycles) -> single wr_enable at N+2, wr_addr=24'h000643, wr_data=16'hF800, fifo_level returns to 0.
REQ-027 Hold busy=1; push 17 pixels back-to-back -> 16 accepted, pix_ready=0, fifo_level=16; release busy -> 16 writes with offsets in push order, no wr_enable while busy=1.
REQ-028 Push (799,599,last=1) then (0,0,last=0) -> first write at wr_addr=24'h0752FF; frame_done pulse on its pop; front_sel 1->0; second write at wr_addr=24'h075300.
REQ-029 Push (800,0) and (0,600,last=1) -> no wr_enable, drop_count=2, front_sel unchanged, pix_ready stays 1.
REQ-030 Assert rst during WAIT_DONE with 5 entries queued -> next cycle fifo_level=0, wr_enable=0, front_sel=1; no further writes until a new push.
REQ-031 At fifo_level=1 in WAIT_DONE, push in the same cycle that busy falls -> fifo_level stays 1, and the new pixel is issued next.
